seq_multiplier: RTL and testbench



---
 rtl/seq_multiplier_pkg.sv | 5 +
 rtl/seq_multiplier_if.sv | 11 +
 rtl/seq_multiplier_datapath.sv | 29 ++
 rtl/seq_multiplier.sv | 57 +++++
 tb/tb_seq_multiplier.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/seq_multiplier_pkg.sv
// seq_multiplier_pkg: shared FSM state encodings and default operand width for the multiplier, result register and ALU
package seq_multiplier_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if: start/a/b request and busy/done/product response bundle; master = ALU control, slave = multiplier
interface seq_multiplier_if import seq_multiplier_pkg::*; #(parameter int WIDTH = WIDTH_DEF);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic [2*WIDTH-1:0] product;
  modport master(output start, a, b, input busy, done, product);
  modport slave(input start, a, b, output busy, done, product);
endinterface

// File: rtl/seq_multiplier_datapath.sv
// seq_multiplier_datapath: shift-add accumulator {upper, multiplier/lower} and multiplicand register; ports clk, reset, load_i (capture a_i/b_i), step_i (one add+shift), acc_nxt_o (accumulator value after this edge)
module seq_multiplier_datapath #(parameter int WIDTH = 8) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] acc_nxt_o
);
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH:0] sum;
  always_comb begin
    sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    acc_d = load_i ? {{WIDTH{1'b0}}, b_i} : step_i ? {sum, acc_q[WIDTH-1:1]} : acc_q;
    mcand_d = load_i ? a_i : mcand_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      mcand_q <= '0;
    end else begin
      acc_q <= acc_d;
      mcand_q <= mcand_d;
    end
  end
  assign acc_nxt_o = acc_d;
endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: unsigned WIDTH-cycle shift-add multiplier; ports clk, reset (sync, active-high), bus (slave: start/a/b in, busy/done/product out)
module seq_multiplier import seq_multiplier_pkg::*; #(parameter int WIDTH = WIDTH_DEF) (
  input logic clk,
  input logic reset,
  seq_multiplier_if.slave bus
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d, acc_nxt;
  logic load, step, last;
  assign last = cnt_q == CW'(WIDTH - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    product_d = product_q;
    load = 1'b0;
    step = 1'b0;
    case (state_q)
      IDLE: begin
        load = bus.start;
        cnt_d = '0;
        state_d = bus.start ? RUN : IDLE;
      end
      RUN: begin
        step = 1'b1;
        cnt_d = last ? '0 : cnt_q + CW'(1);
        state_d = last ? DONE : RUN;
        product_d = last ? acc_nxt : product_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      product_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      product_q <= product_d;
    end
  end
  seq_multiplier_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk(clk),
    .reset(reset),
    .load_i(load),
    .step_i(step),
    .a_i(bus.a),
    .b_i(bus.b),
    .acc_nxt_o(acc_nxt)
  );
  assign bus.busy = state_q == RUN;
  assign bus.done = state_q == DONE;
  assign bus.product = product_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed vector table plus hand-written handshake, throughput, abort and hold sequences
module tb_seq_multiplier;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  seq_multiplier_if #(.WIDTH(8)) bus();
  seq_multiplier #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [15:0] p;
  } vec_t;
  vec_t v[5];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_mult(input logic [7:0] x, input logic [7:0] y, output int nbusy, output int done_at, output logic [15:0] p);
    bus.start = 1'b1;
    bus.a = x;
    bus.b = y;
    tick();
    bus.start = 1'b0;
    bus.a = 8'($urandom);
    bus.b = 8'($urandom);
    nbusy = 0;
    done_at = -1;
    p = 16'hdead;
    for (int c = 1; c <= 20 && done_at < 0; c++) begin
      chk("busy_done_overlap", {31'd0, bus.busy & bus.done}, 32'd0);
      if (bus.busy) nbusy++;
      if (bus.done) begin
        done_at = c;
        p = bus.product;
      end else tick();
    end
    tick();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
  initial begin
    int nb, da;
    logic [15:0] p;
    int rises[$];
    int dones[$];
    logic [15:0] dprod[$];
    logic prev_busy;
    v[0] = '{8'd13, 8'd11, 16'h008F};
    v[1] = '{8'hFF, 8'hFF, 16'hFE01};
    v[2] = '{8'h00, 8'hA5, 16'h0000};
    v[3] = '{8'h01, 8'h80, 16'h0080};
    v[4] = '{8'd6, 8'd7, 16'h002A};
    bus.start = 1'b1;
    bus.a = 8'd9;
    bus.b = 8'd9;
    tick();
    tick();
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_product", {16'd0, bus.product}, 32'd0);
    bus.start = 1'b0;
    reset = 1'b0;
    tick();
    chk("idle_busy", {31'd0, bus.busy}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      do_mult(v[i].a, v[i].b, nb, da, p);
      chk($sformatf("vec%0d_busy_cycles", i), nb, 8);
      chk($sformatf("vec%0d_done_cycle", i), da, 9);
      chk($sformatf("vec%0d_product", i), {16'd0, p}, {16'd0, v[i].p});
    end
    for (int c = 0; c < 20; c++) begin
      chk("hold_done", {31'd0, bus.done}, 32'd0);
      chk("hold_product", {16'd0, bus.product}, 32'h002A);
      tick();
    end
    bus.start = 1'b1;
    bus.a = 8'd3;
    bus.b = 8'd5;
    prev_busy = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      chk("stream_overlap", {31'd0, bus.busy & bus.done}, 32'd0);
      if (bus.busy && !prev_busy) rises.push_back(c);
      if (bus.done) begin
        dones.push_back(c);
        dprod.push_back(bus.product);
      end
      prev_busy = bus.busy;
      if (c == 3) begin
        bus.a = 8'd7;
        bus.b = 8'd7;
      end
      if (c == 29) bus.start = 1'b0;
    end
    chk("stream_idle_after", {31'd0, bus.busy}, 32'd0);
    chk("stream_accepts", rises.size(), 3);
    chk("stream_dones", dones.size(), 3);
    if (rises.size() == 3) begin
      chk("stream_accept1", rises[0], 1);
      chk("stream_period1", rises[1] - rises[0], 10);
      chk("stream_period2", rises[2] - rises[1], 10);
    end
    if (dones.size() == 3) begin
      chk("stream_done1_cycle", dones[0], 9);
      chk("stream_prod1", {16'd0, dprod[0]}, 32'h000F);
      chk("stream_prod2", {16'd0, dprod[1]}, 32'h0031);
      chk("stream_prod3", {16'd0, dprod[2]}, 32'h0031);
    end
    tick();
    bus.start = 1'b1;
    bus.a = 8'd200;
    bus.b = 8'd200;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c < 4; c++) begin
      chk("abort_pre_busy", {31'd0, bus.busy}, 32'd1);
      tick();
    end
    chk("abort_run4_busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    bus.start = 1'b1;
    tick();
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_product", {16'd0, bus.product}, 32'd0);
    reset = 1'b0;
    bus.start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk("abort_no_done", {31'd0, bus.done | bus.busy}, 32'd0);
    end
    do_mult(8'd2, 8'd3, nb, da, p);
    chk("post_abort_cycles", da, 9);
    chk("post_abort_product", {16'd0, p}, 32'h0006);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
